mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one multi-cycle multiplier (enable/done handshake, as used by the Barrett datapath) between N_REQ requesters.
- Typical N_REQ=2: Barrett stage 1 (a_msb*m) and stage 2 (l1_msb*p), so the reduction uses a single multiplier instance.
- Round-robin arbitration, operand capture on accept, and per-requester response pulse.
- One multiplication is in flight at a time.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- A_W, 130, operand A width.
- B_W, 256, operand B width.
- P_W, A_W+B_W, product width.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high reset.
- req_valid, input, N_REQ, per-requester request.
- req_a, input, N_REQ*A_W, packed operand A; requester i occupies [i*A_W +: A_W].
- req_b, input, N_REQ*B_W, packed operand B; same packing.
- req_ready, output, N_REQ, one-hot accept strobe.
- resp_valid, output, N_REQ, one-hot result-valid pulse.
- resp_ab, output, P_W, product; valid while any resp_valid bit is high.
- mul_enable, output, 1, multiplier enable.
- mul_a, output, A_W, operand A to the multiplier.
- mul_b, output, B_W, operand B to the multiplier.
- mul_done, input, 1, multiplier result valid.
- mul_ab, input, P_W, multiplier product.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_ab=0, mul_enable=0, mul_a=0, mul_b=0, busy=0. Reset asserted mid-operation abandons the operation: no resp_valid, and mul_enable drops immediately.
- States: IDLE, RUN, RESP, DRAIN.
- IDLE:
  - If any req_valid, grant index g = first set bit scanning from rr_ptr upward, with wrap.
  - Same cycle (combinational): req_ready[g]=1.
  - Next edge: latch mul_a/mul_b from slot g, store g, go to RUN.
  - A request is accepted only when req_valid and req_ready are both high. The requester must hold operands stable until then.
- RUN:
  - mul_enable=1; mul_a/mul_b stay stable.
  - On mul_done=1: latch resp_ab=mul_ab, go to RESP.
- RESP:
  - One-cycle pulse resp_valid[g]=1; mul_enable=0.
  - rr_ptr = (g+1) mod N_REQ.
  - Next state: DRAIN if mul_done is still 1, else IDLE.
- DRAIN:
  - Waits for mul_done=0, then goes to IDLE. This prevents a stale done from being taken as the completion of the next operation.
- resp_ab holds its value until the next RESP.
- req_ready is never asserted outside IDLE. Requests arriving while busy wait; no queueing inside the block.
- Minimum turnaround: accept cycle + RUN (≥1 cycle) + RESP = 3 cycles plus multiplier latency.
- Simultaneous events:
  - All requesters valid: strict rotation g, g+1, ...; no requester waits more than N_REQ-1 grants.
  - req_valid[i] deasserted before accept: request is dropped silently, no error.
  - mul_done already high on entry to RUN (multiplier not yet cleared): DRAIN guarantees this cannot happen.
- Arithmetic: none in the block; product width is fixed at P_W, no truncation.
- mul_done while not in RUN is ignored.

Decomposition:
- Shared package mul_pkg:
  - state enum (IDLE/RUN/RESP/DRAIN);
  - localparams A_W/B_W/P_W defaults for the 128-bit configuration;
  - function clog2 for the rr_ptr width.
- Sub-module rr_arbiter (N_REQ param; inputs req, ptr; outputs one-hot grant and index). Purely combinational; reused by later point-adder scheduling.

Test Plan:
- Single request, small config: A_W=8, B_W=8; req_valid=01, a=12, b=13; multiplier model latency 4.
  - Expect: req_ready=01 for 1 cycle, mul_enable high for 4+ cycles, resp_valid=01 pulse, resp_ab=156, busy low afterwards.
- Contention: both valid continuously; req0 a=3,b=5; req1 a=7,b=11.
  - Expect grant order 0,1,0,1.
  - Expect responses 15, 77, 15, 77 on resp_valid 01, 10, 01, 10.
- Sticky done: model holds mul_done high for 3 cycles after enable drops.
  - Expect FSM in DRAIN; next grant only after done falls.
  - Expect exactly one resp_valid per request.
- Reset mid-RUN: assert reset 2 cycles into RUN.
  - Expect all outputs zero immediately (async) and no resp_valid.
  - After release, a fresh request a=2, b=9 returns 18.
- Withdrawn request: req_valid[1] pulsed while busy serving req0 and dropped before IDLE.
  - Expect no grant to 1 and rr_ptr=1 retained.
- Boundary: a=255, b=255 (A_W=B_W=8).
  - Expect resp_ab=65025, full P_W=16 bits, no truncation.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier-sharing logic around the Barrett datapath.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int MUL_A_W = 130;
    localparam int MUL_B_W = 256;
    localparam int MUL_P_W = MUL_A_W + MUL_B_W;

    // Width of an index into n entries, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
    import mul_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int w_d;

    // Outer loop walks priority distance from ptr, so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_d   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                w_d = i - int'(ptr);
                if (w_d < 0) w_d = w_d + N_REQ;
                if (!any && req[i] && (w_d == k)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that lets N_REQ clients share one enable/done multiplier,
// one operation in flight at a time.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int A_W   = MUL_A_W,
    parameter int B_W   = MUL_B_W,
    parameter int P_W   = A_W + B_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [P_W-1:0]     resp_ab,
    output logic               mul_enable,
    output logic [A_W-1:0]     mul_a,
    output logic [B_W-1:0]     mul_b,
    input  logic               mul_done,
    input  logic [P_W-1:0]     mul_ab,
    output logic               busy
);

    localparam int PTR_W = clog2(N_REQ);

    state_t           r_state;
    state_t           w_next;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_gidx;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [N_REQ-1:0] w_grant;
    logic             w_any;
    logic [A_W-1:0]   r_mul_a;
    logic [B_W-1:0]   r_mul_b;
    logic [P_W-1:0]   r_resp_ab;
    logic [A_W-1:0]   w_sel_a;
    logic [B_W-1:0]   w_sel_b;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*A_W +: A_W];
                w_sel_b = req_b[i*B_W +: B_W];
            end
        end
    end

    assign w_ptr_nxt = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // DRAIN keeps a lingering done from being mistaken for the next completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any)     w_next = RUN;
            RUN:     if (mul_done)  w_next = RESP;
            RESP:    w_next = mul_done ? DRAIN : IDLE;
            DRAIN:   if (!mul_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        mul_enable = (r_state == RUN);
        busy       = (r_state != IDLE);
        if (r_state == IDLE && !reset) req_ready = w_grant;
        for (int i = 0; i < N_REQ; i++)
            resp_valid[i] = (r_state == RESP) && (r_gidx == PTR_W'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_gidx    <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_resp_ab <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_mul_a <= w_sel_a;
                    r_mul_b <= w_sel_b;
                    r_gidx  <= w_idx;
                end
                RUN:  if (mul_done) r_resp_ab <= mul_ab;
                RESP: r_rr_ptr <= w_ptr_nxt;
                default: ;
            endcase
        end
    end

    assign mul_a   = r_mul_a;
    assign mul_b   = r_mul_b;
    assign resp_ab = r_resp_ab;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a latency-4 multiplier model and optional sticky done.
module tb_mul_share_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = 16;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [PW-1:0]   resp_ab;
    logic            mul_enable;
    logic [AW-1:0]   mul_a;
    logic [BW-1:0]   mul_b;
    logic            mul_done;
    logic [PW-1:0]   mul_ab;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;
    int sticky = 0;
    int m_cnt, m_hold;
    int n_resp0 = 0, n_resp1 = 0, n_rwd = 0;

    mul_share_arbiter #(.N_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ab    (resp_ab),
        .mul_enable (mul_enable),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_ab     (mul_ab),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: done LAT cycles into enable, held `sticky` extra cycles after enable drops.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt <= 0; m_hold <= 0; mul_done <= 1'b0; mul_ab <= '0;
        end else if (mul_enable) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 1) begin
                mul_done <= 1'b1;
                mul_ab   <= {8'd0, mul_a} * {8'd0, mul_b};
                m_hold   <= sticky;
            end
        end else begin
            m_cnt <= 0;
            if (m_hold > 0) m_hold <= m_hold - 1;
            else            mul_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (resp_valid[0]) n_resp0 <= n_resp0 + 1;
        if (resp_valid[1]) n_resp1 <= n_resp1 + 1;
        if (req_ready != '0 && mul_done) n_rwd <= n_rwd + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait for a grant, check it, drop `clr` bits after accept, then wait for the response.
    task automatic serve(input string tag, input logic [1:0] exp_g, input logic [1:0] clr,
                         input logic [7:0] ea, input logic [7:0] eb, input logic [15:0] eab);
        int t;
        int en;
        t = 0;
        do begin @(negedge clk); t++; end while (req_ready == '0 && t < 100);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_g));
        @(posedge clk); #1;
        req_valid = req_valid & ~clr;
        @(negedge clk);
        check({tag, "_ready_off"}, 32'(req_ready), 32'd0);
        check({tag, "_mul_a"}, 32'(mul_a), 32'(ea));
        check({tag, "_mul_b"}, 32'(mul_b), 32'(eb));
        en = mul_enable ? 1 : 0;
        t = 0;
        while (resp_valid == '0 && t < 100) begin
            @(negedge clk); t++;
            if (mul_enable) en++;
        end
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'(exp_g));
        check({tag, "_resp_ab"}, 32'(resp_ab), 32'(eab));
        check({tag, "_en_cycles_ge4"}, 32'(en >= LAT), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 100) begin @(negedge clk); t++; end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s0, s1, sr;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_ab", 32'(resp_ab), 32'd0);
        check("rst_enable", 32'(mul_enable), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        // Single request on slot 0: 12*13
        @(posedge clk); #1;
        req_a = {8'd0, 8'd12}; req_b = {8'd0, 8'd13}; req_valid = 2'b01;
        serve("single", 2'b01, 2'b01, 8'd12, 8'd13, 16'd156);
        wait_idle("single");
        check("single_hold_ab", 32'(resp_ab), 32'd156);

        // Boundary 255*255 on slot 1 (pointer now at 1)
        @(posedge clk); #1;
        req_a = {8'd255, 8'd0}; req_b = {8'd255, 8'd0}; req_valid = 2'b10;
        serve("bound", 2'b10, 2'b10, 8'd255, 8'd255, 16'd65025);
        wait_idle("bound");

        // Contention with pointer back at 0
        @(posedge clk); #1;
        req_a = {8'd7, 8'd3}; req_b = {8'd11, 8'd5}; req_valid = 2'b11;
        serve("cont0", 2'b01, 2'b00, 8'd3, 8'd5, 16'd15);
        serve("cont1", 2'b10, 2'b00, 8'd7, 8'd11, 16'd77);
        serve("cont2", 2'b01, 2'b00, 8'd3, 8'd5, 16'd15);
        serve("cont3", 2'b10, 2'b11, 8'd7, 8'd11, 16'd77);
        wait_idle("cont");

        // Sticky done: done held 3 extra cycles, FSM must sit in DRAIN
        sticky = 3;
        s0 = n_resp0; s1 = n_resp1; sr = n_rwd;
        @(posedge clk); #1;
        req_a = {8'd10, 8'd4}; req_b = {8'd10, 8'd6}; req_valid = 2'b11;
        serve("stk0", 2'b01, 2'b01, 8'd4, 8'd6, 16'd24);
        @(negedge clk);
        check("stk_drain_busy", 32'(busy), 32'd1);
        check("stk_drain_done", 32'(mul_done), 32'd1);
        check("stk_drain_ready", 32'(req_ready), 32'd0);
        serve("stk1", 2'b10, 2'b10, 8'd10, 8'd10, 16'd100);
        wait_idle("stk");
        repeat (6) @(negedge clk);
        check("stk_resp0_count", 32'(n_resp0 - s0), 32'd1);
        check("stk_resp1_count", 32'(n_resp1 - s1), 32'd1);
        check("stk_ready_while_done", 32'(n_rwd - sr), 32'd0);
        sticky = 0;

        // Withdrawn request on slot 1 while slot 0 is being served
        @(posedge clk); #1;
        req_a = {8'd6, 8'd5}; req_b = {8'd7, 8'd5}; req_valid = 2'b01;
        fork
            serve("wd_first", 2'b01, 2'b01, 8'd5, 8'd5, 16'd25);
            begin
                repeat (3) @(posedge clk); #1; req_valid[1] = 1'b1;
                @(posedge clk); #1; req_valid[1] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("wd_no_grant", 32'(req_ready), 32'd0);
        check("wd_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b11;
        serve("wd_ptr1", 2'b10, 2'b10, 8'd6, 8'd7, 16'd42);
        serve("wd_ptr0", 2'b01, 2'b01, 8'd5, 8'd5, 16'd25);
        wait_idle("wd");

        // Reset two cycles into RUN abandons the operation
        s0 = n_resp0; s1 = n_resp1;
        @(posedge clk); #1;
        req_a = {8'd0, 8'd2}; req_b = {8'd0, 8'd9}; req_valid = 2'b01;
        @(negedge clk);
        check("rmid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1; req_valid = 2'b00;
        @(posedge clk); @(posedge clk); #2;
        check("rmid_enable_pre", 32'(mul_enable), 32'd1);
        reset = 1'b1; #1;
        check("rmid_enable", 32'(mul_enable), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_resp_valid", 32'(resp_valid), 32'd0);
        check("rmid_resp_ab", 32'(resp_ab), 32'd0);
        check("rmid_mul_a", 32'(mul_a), 32'd0);
        check("rmid_mul_b", 32'(mul_b), 32'd0);
        repeat (2) @(posedge clk); #1; reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rmid_no_resp", 32'(n_resp0 - s0 + n_resp1 - s1), 32'd0);
        @(posedge clk); #1; req_valid = 2'b01;
        serve("rmid_fresh", 2'b01, 2'b01, 8'd2, 8'd9, 16'd18);
        wait_idle("rmid");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
